multi_channel_average: RTL and testbench

Parametrised successor to the two-channel frame averager in the thermovision ADC path. It accumulates a power-of-two number of samples per frame on CHANNELS parallel ADC streams, then produces per-channel sums, means and a control checksum. A pedestal (dark-level) frame can be captured on request and stored per channel, and optionally subtracted from later means. It sits between the ADC capture front end and the frame/readout logic, and is controlled by the sequencer's START/SAMPLE_VALID strobes.

---
 rtl/multi_channel_average_pkg.sv | 12 +
 rtl/multi_channel_average_avg_channel_acc.sv | 70 +++++++
 rtl/multi_channel_average.sv | 138 +++++++++++++
 tb/tb_multi_channel_average.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_average_pkg.sv
// Shared types and defaults for the multi-channel frame averager.
package multi_channel_average_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } avg_state_e;

    localparam int unsigned DefaultAdcWidth = 14;

endpackage

// File: rtl/multi_channel_average_avg_channel_acc.sv
// One channel of the averager: accumulator, mean shift, pedestal store and,
// with AVG_PED_SUBTRACT_EN defined, a clamping pedestal subtractor.
module multi_channel_average_avg_channel_acc #(
    parameter int unsigned ADC_WIDTH    = 14,
    parameter int unsigned LOG2_SAMPLES = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               add,
    input  logic                               capture,
    input  logic                               ped_frame,
    input  logic [ADC_WIDTH-1:0]               sample,
    output logic [ADC_WIDTH-1:0]               acc_low,
    output logic [ADC_WIDTH+LOG2_SAMPLES-1:0]  sum,
    output logic [ADC_WIDTH-1:0]               mean,
    output logic [ADC_WIDTH-1:0]               pedestal
);

    localparam int unsigned SUM_WIDTH = ADC_WIDTH + LOG2_SAMPLES;

    logic [SUM_WIDTH-1:0] acc_q;
    logic [SUM_WIDTH-1:0] sum_q;
    logic [ADC_WIDTH-1:0] mean_q;
    logic [ADC_WIDTH-1:0] ped_q;
    logic [ADC_WIDTH-1:0] raw_mean;
    logic [ADC_WIDTH-1:0] mean_d;

    assign raw_mean = acc_q[SUM_WIDTH-1:LOG2_SAMPLES];

`ifdef AVG_PED_SUBTRACT_EN
    // Pedestal frames report the raw mean; others subtract the stored dark level.
    always_comb begin
        mean_d = raw_mean;
        if (!ped_frame) begin
            mean_d = (raw_mean > ped_q) ? (raw_mean - ped_q) : '0;
        end
    end
`else
    assign mean_d = raw_mean;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            sum_q  <= '0;
            mean_q <= '0;
            ped_q  <= '0;
        end else begin
            if (clear) begin
                acc_q <= '0;
            end else if (add) begin
                acc_q <= acc_q + SUM_WIDTH'(sample);
            end
            if (capture) begin
                sum_q  <= acc_q;
                mean_q <= mean_d;
                if (ped_frame) begin
                    ped_q <= raw_mean;
                end
            end
        end
    end

    assign acc_low  = acc_q[ADC_WIDTH-1:0];
    assign sum      = sum_q;
    assign mean     = mean_q;
    assign pedestal = ped_q;

endmodule

// File: rtl/multi_channel_average.sv
// Frame averager over CHANNELS ADC streams: FSM, input pipe, sample counter and
// checksum. Build with AVG_PED_SUBTRACT_EN to subtract stored pedestals from means.
module multi_channel_average
    import multi_channel_average_pkg::*;
#(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned ADC_WIDTH    = DefaultAdcWidth,
    parameter int unsigned LOG2_SAMPLES = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        ped_mode,
    input  logic                                        sample_valid,
    input  logic [CHANNELS*ADC_WIDTH-1:0]               adc_in,
    output logic                                        busy,
    output logic                                        result_valid,
    output logic [CHANNELS*(ADC_WIDTH+LOG2_SAMPLES)-1:0] sum,
    output logic [CHANNELS*ADC_WIDTH-1:0]               mean,
    output logic [CHANNELS*ADC_WIDTH-1:0]               pedestal,
    output logic [ADC_WIDTH-1:0]                        contr_sum,
    output logic [LOG2_SAMPLES:0]                       sample_cnt
);

    localparam int unsigned SUM_WIDTH = ADC_WIDTH + LOG2_SAMPLES;
    localparam logic [LOG2_SAMPLES:0] FullCnt = {1'b1, {LOG2_SAMPLES{1'b0}}};

    avg_state_e state_q, state_d;

    logic [CHANNELS*ADC_WIDTH-1:0] adc_q;
    logic                          valid_q;
    logic [LOG2_SAMPLES:0]         cnt_q;
    logic                          ped_frame_q;
    logic                          busy_q;
    logic                          result_valid_q;
    logic [ADC_WIDTH-1:0]          contr_q;

    logic clear;
    logic add;
    logic capture;

    logic [ADC_WIDTH-1:0] acc_low [CHANNELS];
    logic [ADC_WIDTH-1:0] csum;

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        add     = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    clear   = 1'b1;
                end
            end
            StAccum: begin
                // Restart wins over a sample registered in the same cycle.
                if (start) begin
                    clear = 1'b1;
                end else if (cnt_q == FullCnt) begin
                    state_d = StDone;
                end else if (valid_q) begin
                    add = 1'b1;
                end
            end
            StDone: begin
                capture = 1'b1;
                clear   = start;
                state_d = start ? StAccum : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Low bits suffice: the checksum is taken modulo 2^ADC_WIDTH.
    always_comb begin
        csum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            csum = csum + acc_low[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            adc_q          <= '0;
            valid_q        <= 1'b0;
            cnt_q          <= '0;
            ped_frame_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            contr_q        <= '0;
        end else begin
            state_q        <= state_d;
            adc_q          <= adc_in;
            valid_q        <= sample_valid;
            busy_q         <= (state_d != StIdle);
            result_valid_q <= capture;
            if (start) begin
                ped_frame_q <= ped_mode;
            end
            if (clear) begin
                cnt_q <= '0;
            end else if (add) begin
                cnt_q <= cnt_q + (LOG2_SAMPLES + 1)'(1);
            end
            if (capture) begin
                contr_q <= csum;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        multi_channel_average_avg_channel_acc #(
            .ADC_WIDTH   (ADC_WIDTH),
            .LOG2_SAMPLES(LOG2_SAMPLES)
        ) u_acc (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .add      (add),
            .capture  (capture),
            .ped_frame(ped_frame_q),
            .sample   (adc_q[g*ADC_WIDTH +: ADC_WIDTH]),
            .acc_low  (acc_low[g]),
            .sum      (sum[g*SUM_WIDTH +: SUM_WIDTH]),
            .mean     (mean[g*ADC_WIDTH +: ADC_WIDTH]),
            .pedestal (pedestal[g*ADC_WIDTH +: ADC_WIDTH])
        );
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign contr_sum    = contr_q;
    assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_multi_channel_average.sv
// Directed self-checking bench for multi_channel_average (2 channels, 4 samples/frame).
module tb_multi_channel_average;

    localparam int unsigned CH = 2;
    localparam int unsigned AW = 14;
    localparam int unsigned L2 = 2;
    localparam int unsigned SW = AW + L2;

    logic              clk;
    logic              reset;
    logic              start;
    logic              ped_mode;
    logic              sample_valid;
    logic [CH*AW-1:0]  adc_in;
    logic              busy;
    logic              result_valid;
    logic [CH*SW-1:0]  sum;
    logic [CH*AW-1:0]  mean;
    logic [CH*AW-1:0]  pedestal;
    logic [AW-1:0]     contr_sum;
    logic [L2:0]       sample_cnt;

    int n_tests;
    int n_fail;

    multi_channel_average #(
        .CHANNELS    (CH),
        .ADC_WIDTH   (AW),
        .LOG2_SAMPLES(L2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ped_mode    (ped_mode),
        .sample_valid(sample_valid),
        .adc_in      (adc_in),
        .busy        (busy),
        .result_valid(result_valid),
        .sum         (sum),
        .mean        (mean),
        .pedestal    (pedestal),
        .contr_sum   (contr_sum),
        .sample_cnt  (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic ped);
        start    = 1'b1;
        ped_mode = ped;
        tick();
        start    = 1'b0;
        ped_mode = 1'b0;
    endtask

    task automatic send(input int a0, input int a1);
        sample_valid = 1'b1;
        adc_in       = {AW'(a1), AW'(a0)};
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for the result pulse; returns cycles waited (0 if never seen).
    task automatic wait_result(input string tag, output int lat);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (result_valid) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, 64'(seen), 64'd1);
        lat = seen ? n : 0;
    endtask

    task automatic check_frame(input string tag, input int s0, input int s1,
                               input int m0, input int m1);
        check_eq({tag, "_sum0"},  64'(sum[0 +: SW]),  64'(s0));
        check_eq({tag, "_sum1"},  64'(sum[SW +: SW]), 64'(s1));
        check_eq({tag, "_mean0"}, 64'(mean[0 +: AW]), 64'(m0));
        check_eq({tag, "_mean1"}, 64'(mean[AW +: AW]), 64'(m1));
    endtask

    initial begin
        int lat;
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        start        = 1'b0;
        ped_mode     = 1'b0;
        sample_valid = 1'b0;
        adc_in       = '0;
        idle(2);
        reset = 1'b0;
        tick();

        check_eq("rst_busy",  64'(busy), 64'd0);
        check_eq("rst_rv",    64'(result_valid), 64'd0);
        check_eq("rst_sum",   64'(sum), 64'd0);
        check_eq("rst_mean",  64'(mean), 64'd0);
        check_eq("rst_ped",   64'(pedestal), 64'd0);
        check_eq("rst_contr", 64'(contr_sum), 64'd0);
        check_eq("rst_cnt",   64'(sample_cnt), 64'd0);

        // Samples while idle are ignored.
        send(77, 77);
        idle(2);
        check_eq("idle_cnt",  64'(sample_cnt), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);

        // Constant frame, back-to-back samples.
        do_start(1'b0);
        check_eq("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) send(100, 200);
        wait_result("t1", lat);
        check_eq("t1_lat", 64'(lat), 64'd3);
        check_frame("t1", 400, 800, 100, 200);
        check_eq("t1_contr", 64'(contr_sum), 64'd1200);
        check_eq("t1_cnt", 64'(sample_cnt), 64'd4);
        check_eq("t1_busy_done", 64'(busy), 64'd0);
        tick();
        check_eq("t1_rv_pulse", 64'(result_valid), 64'd0);

        // Gapped samples; busy must hold through the gaps.
        do_start(1'b0);
        send(1, 0);
        idle(5);
        check_eq("t3_busy_gap", 64'(busy), 64'd1);
        send(2, 0);
        idle(2);
        send(3, 0);
        idle(3);
        check_eq("t3_cnt", 64'(sample_cnt), 64'd3);
        send(6, 0);
        wait_result("t3", lat);
        check_frame("t3", 12, 0, 3, 0);
        check_eq("t3_contr", 64'(contr_sum), 64'd12);

        // Restart after two samples; the sample registered with START is dropped.
        do_start(1'b0);
        send(1000, 1000);
        send(1000, 1000);
        check_eq("t4_cnt_mid", 64'(sample_cnt), 64'd1);
        do_start(1'b0);
        check_eq("t4_cnt_clr", 64'(sample_cnt), 64'd0);
        for (int i = 0; i < 4; i++) send(10, 10);
        wait_result("t4", lat);
        check_frame("t4", 40, 40, 10, 10);

        // Full-scale samples plus a surplus fifth sample that must be dropped.
        do_start(1'b0);
        for (int i = 0; i < 5; i++) send(16383, 16383);
        wait_result("t5", lat);
        check_frame("t5", 65532, 65532, 16383, 16383);
        check_eq("t5_contr", 64'(contr_sum), 64'd16376);

        // Pedestal frame, then normal frames.
        do_start(1'b1);
        for (int i = 0; i < 4; i++) send(50, 60);
        wait_result("t2p", lat);
        check_frame("t2p", 200, 240, 50, 60);
        check_eq("t2p_ped0", 64'(pedestal[0 +: AW]), 64'd50);
        check_eq("t2p_ped1", 64'(pedestal[AW +: AW]), 64'd60);

        do_start(1'b0);
        for (int i = 0; i < 4; i++) send(100, 200);
        wait_result("t2n", lat);
`ifdef AVG_PED_SUBTRACT_EN
        check_frame("t2n", 400, 800, 50, 140);
`else
        check_frame("t2n", 400, 800, 100, 200);
`endif
        check_eq("t2n_ped0", 64'(pedestal[0 +: AW]), 64'd50);
        check_eq("t2n_ped1", 64'(pedestal[AW +: AW]), 64'd60);

        do_start(1'b0);
        for (int i = 0; i < 4; i++) send(30, 30);
        wait_result("t2c", lat);
`ifdef AVG_PED_SUBTRACT_EN
        check_frame("t2c", 120, 120, 0, 0);
`else
        check_frame("t2c", 120, 120, 30, 30);
`endif

        // Asynchronous reset in the middle of a frame clears everything.
        do_start(1'b0);
        send(5, 5);
        send(5, 5);
        reset = 1'b1;
        #1;
        check_eq("t6_busy",  64'(busy), 64'd0);
        check_eq("t6_rv",    64'(result_valid), 64'd0);
        check_eq("t6_sum",   64'(sum), 64'd0);
        check_eq("t6_mean",  64'(mean), 64'd0);
        check_eq("t6_ped",   64'(pedestal), 64'd0);
        check_eq("t6_contr", 64'(contr_sum), 64'd0);
        check_eq("t6_cnt",   64'(sample_cnt), 64'd0);
        idle(1);
        reset = 1'b0;
        send(9, 9);
        idle(3);
        check_eq("t6_idle_cnt",  64'(sample_cnt), 64'd0);
        check_eq("t6_idle_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
